// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker: exhaustive truth-table sweep checker for a combinational stage (optional SWEEP_STOP_ON_FAIL_EN)
module minterm_sweep_checker #(
  parameter int N_VARS        = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1<<N_VARS)-1:0]  golden_tt,
  input  logic [(1<<N_VARS)-1:0]  dont_care,
  input  logic                    f_in,
  output logic [N_VARS-1:0]       vars_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_VARS:0]         mismatch_count,
  output logic [N_VARS-1:0]       first_fail_idx,
  output logic                    first_fail_valid
);
  localparam int TT = 1 << N_VARS;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;
  state_t            r_state;
  logic [TT-1:0]     r_gold;
  logic [TT-1:0]     r_dc;
  logic [N_VARS-1:0] r_idx;
  logic [3:0]        r_cnt;
  logic [N_VARS:0]   r_mc;
  logic [N_VARS-1:0] r_ffi;
  logic              r_ffv;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              w_miss;
  logic              w_last;
  logic              w_stop;
  logic [N_VARS:0]   w_mc_next;
  // a minterm counts as failing only when it is not masked by the don't-care snapshot
  always_comb begin
    w_miss    = (f_in != r_gold[r_idx]) && !r_dc[r_idx];
    w_last    = r_idx == {N_VARS{1'b1}};
    w_mc_next = r_mc + {{N_VARS{1'b0}}, w_miss};
`ifdef SWEEP_STOP_ON_FAIL_EN
    w_stop    = w_last || w_miss;
`else
    w_stop    = w_last;
`endif
  end
  // sweep sequencer: snapshot on start, settle each vector, compare, then report
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gold  <= '0;
      r_dc    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_mc    <= '0;
      r_ffi   <= '0;
      r_ffv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: if (start) begin
          r_gold  <= golden_tt;
          r_dc    <= dont_care;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_mc    <= '0;
          r_pass  <= 1'b0;
          r_ffv   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= (SETTLE_CYCLES == 0) ? CHECK : DRIVE;
        end
        DRIVE: if (r_cnt == 4'(SETTLE_CYCLES - 1)) r_state <= CHECK;
               else r_cnt <= r_cnt + 4'd1;
        CHECK: begin
          r_mc <= w_mc_next;
          if (w_miss && !r_ffv) begin
            r_ffi <= r_idx;
            r_ffv <= 1'b1;
          end
          if (w_stop) begin
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_mc_next == '0;
            r_state <= FINISH;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= '0;
            r_state <= (SETTLE_CYCLES == 0) ? CHECK : DRIVE;
          end
        end
        FINISH: r_state <= IDLE;
      endcase
    end
  end
  assign vars_out         = r_idx;
  assign busy             = r_busy;
  assign done             = r_done;
  assign pass             = r_pass;
  assign mismatch_count   = r_mc;
  assign first_fail_idx   = r_ffi;
  assign first_fail_valid = r_ffv;
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// tb_minterm_sweep_checker: table-driven sweeps over three settle settings plus reset/restart sequences
module tb_minterm_sweep_checker;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam int S [3] = '{1, 0, 3};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] golden_tt = '0;
  logic [31:0] dont_care = '0;
  int          mode = 0;
  logic [4:0]  vo  [3];
  logic        bz  [3];
  logic        dn  [3];
  logic        ps  [3];
  logic [5:0]  mc  [3];
  logic [4:0]  ffi [3];
  logic        ffv [3];
  logic        fi  [3];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dcyc [3];
  int          shape_bad;
  int          pulse_bad;
  always #5 clk = ~clk;
  function automatic logic fm(int md, logic [4:0] v);
    return md == 0 ? 1'b1 : md == 1 ? v[0] : md == 2 ? (v == 5'd19) : (v == 5'd7);
  endfunction
  always_comb begin
    fi[0] = fm(mode, vo[0]);
    fi[1] = fm(mode, vo[1]);
    fi[2] = fm(mode, vo[2]);
  end
  minterm_sweep_checker #(.N_VARS(5), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start), .golden_tt(golden_tt), .dont_care(dont_care),
    .f_in(fi[0]), .vars_out(vo[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]),
    .mismatch_count(mc[0]), .first_fail_idx(ffi[0]), .first_fail_valid(ffv[0]));
  minterm_sweep_checker #(.N_VARS(5), .SETTLE_CYCLES(0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start), .golden_tt(golden_tt), .dont_care(dont_care),
    .f_in(fi[1]), .vars_out(vo[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]),
    .mismatch_count(mc[1]), .first_fail_idx(ffi[1]), .first_fail_valid(ffv[1]));
  minterm_sweep_checker #(.N_VARS(5), .SETTLE_CYCLES(3)) dut_s3 (
    .clk(clk), .rst(rst), .start(start), .golden_tt(golden_tt), .dont_care(dont_care),
    .f_in(fi[2]), .vars_out(vo[2]), .busy(bz[2]), .done(dn[2]), .pass(ps[2]),
    .mismatch_count(mc[2]), .first_fail_idx(ffi[2]), .first_fail_valid(ffv[2]));
  typedef struct {
    logic [31:0] golden;
    logic [31:0] dc;
    int          md;
    int          mcnt;
    bit          fvalid;
    int          fidx;
  } vec_t;
  vec_t tv [8];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  function automatic int exp_done(int s, int ffk);
    return (STOP && ffk >= 0) ? (s + 1) * (ffk + 1) + 1 : 32 * (s + 1) + 1;
  endfunction
  task automatic run_sweep(input int restart_at);
    bit seen [3];
    shape_bad = 0;
    pulse_bad = 0;
    for (int i = 0; i < 3; i++) begin
      dcyc[i] = -1;
      seen[i] = 1'b0;
    end
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 300 && !(seen[0] && seen[1] && seen[2]); n++) begin
      @(negedge clk);
      start = (n == restart_at);
      if (restart_at > 0 && n == 5) golden_tt = ~golden_tt;
      for (int i = 0; i < 3; i++) begin
        if (seen[i]) begin
          if (n == dcyc[i] + 1 && dn[i] !== 1'b0) pulse_bad++;
        end else if (dn[i] === 1'b1) begin
          seen[i] = 1'b1;
          dcyc[i] = n;
          if (vo[i] !== 5'd0 || bz[i] !== 1'b0) shape_bad++;
        end else if (vo[i] !== 5'((n - 1) / (S[i] + 1)) || bz[i] !== 1'b1) shape_bad++;
      end
    end
    start = 1'b0;
  endtask
  initial begin
    int ffk;
    int mce;
    int cnt;
    tv[0] = '{32'hFFFF_FFFF, 32'h0,         0, 0,  1'b0, 0};
    tv[1] = '{32'hAAAA_AAAA, 32'h0,         1, 0,  1'b0, 0};
    tv[2] = '{32'h5555_5555, 32'h0,         1, 32, 1'b1, 0};
    tv[3] = '{32'h0,         32'h0,         2, 1,  1'b1, 19};
    tv[4] = '{32'h0,         32'h0008_0000, 2, 0,  1'b0, 0};
    tv[5] = '{32'h0,         32'h0,         3, 1,  1'b1, 7};
    tv[6] = '{32'h0,         32'hFFFF_FFFF, 0, 0,  1'b0, 0};
    tv[7] = '{32'h0,         32'hFFFF_FF00, 0, 8,  1'b1, 0};
    repeat (3) @(negedge clk);
    chk("reset_state", {vo[0], bz[0], dn[0], ps[0], mc[0], ffi[0], ffv[0]}, 64'd0);
    rst = 1'b0;
    for (int r = 0; r < 8; r++) begin
      golden_tt = tv[r].golden;
      dont_care = tv[r].dc;
      mode      = tv[r].md;
      run_sweep(0);
      ffk = tv[r].fvalid ? tv[r].fidx : -1;
      mce = (STOP && tv[r].fvalid) ? 1 : tv[r].mcnt;
      chk($sformatf("done_cyc_s1_r%0d", r), dcyc[0], exp_done(1, ffk));
      chk($sformatf("done_cyc_s0_r%0d", r), dcyc[1], exp_done(0, ffk));
      chk($sformatf("done_cyc_s3_r%0d", r), dcyc[2], exp_done(3, ffk));
      chk($sformatf("vector_shape_r%0d", r), shape_bad, 0);
      chk($sformatf("done_pulse_r%0d", r), pulse_bad, 0);
      chk($sformatf("mismatch_count_r%0d", r), mc[0], mce);
      chk($sformatf("pass_r%0d", r), ps[0], mce == 0);
      chk($sformatf("ffv_r%0d", r), ffv[0], tv[r].fvalid);
      if (tv[r].fvalid) chk($sformatf("ffi_r%0d", r), ffi[0], tv[r].fidx);
    end
    golden_tt = 32'hFFFF_FFFF;
    dont_care = '0;
    mode      = 0;
    run_sweep(10);
    chk("restart_ignored_done", dcyc[0], 65);
    chk("restart_ignored_pass", ps[0], 1'b1);
    chk("restart_ignored_mc", mc[0], 0);
    golden_tt = 32'hFFFF_FFFF;
    run_sweep(65);
    chk("finish_start_done", dcyc[0], 65);
    chk("finish_start_ignored", bz[0], 1'b0);
    repeat (40) @(negedge clk);
    golden_tt = 32'h5555_5555;
    mode      = 1;
    start     = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 20) rst = 1'b1;
    end
    @(negedge clk);
    chk("midsweep_reset_s1", {vo[0], bz[0], dn[0], ps[0], mc[0], ffi[0], ffv[0]}, 64'd0);
    chk("midsweep_reset_s3", {vo[2], bz[2], dn[2], ps[2], mc[2], ffi[2], ffv[2]}, 64'd0);
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (dn[0] || dn[1] || dn[2] || bz[0] || bz[2]) cnt++;
    end
    chk("no_done_after_reset", cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
